vga_timing_gen: RTL

- Parametrised VGA raster timing generator; successor to the fixed 640x480 sync generator.
- Adds configurable timing, selectable sync polarity, a pixel-clock prescaler and a run enable.
- Adds line/frame strobes and a frame counter; all outputs are registered and mutually aligned.
- Sits between the top-level clock/reset and the pixel-pattern logic that drives the TinyVGA PMOD.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_timing_if.sv | 17 +
 rtl/vga_axis_counter.sv | 43 ++++
 rtl/vga_timing_gen.sv | 79 +++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: VGA timing presets and derived-value helpers
package vga_timing_pkg;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_POL       = 0;

    localparam int SVGA_H_DISPLAY = 800;
    localparam int SVGA_H_FRONT   = 40;
    localparam int SVGA_H_SYNC    = 128;
    localparam int SVGA_H_BACK    = 88;
    localparam int SVGA_V_DISPLAY = 600;
    localparam int SVGA_V_FRONT   = 1;
    localparam int SVGA_V_SYNC    = 4;
    localparam int SVGA_V_BACK    = 23;
    localparam int SVGA_POL       = 1;

    function automatic int axis_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    function automatic int sync_start(int display, int front);
        return display + front;
    endfunction

    function automatic int sync_end(int display, int front, int sync);
        return display + front + sync - 1;
    endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the generator to the pixel logic
interface vga_timing_if #(
    parameter int POS_W   = 10,
    parameter int FRAME_W = 8
);
    logic               hsync;
    logic               vsync;
    logic               display_on;
    logic [POS_W-1:0]   hpos;
    logic [POS_W-1:0]   vpos;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (output hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_cnt);
    modport slave  (input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis with registered sync/visible decode of the incoming position
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY = VGA_H_DISPLAY,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK,
    parameter int POL     = VGA_POL,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         visible,
    output logic         wrap
);
    localparam logic [W-1:0] LAST    = W'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
    localparam logic [W-1:0] S_START = W'(sync_start(DISPLAY, FRONT));
    localparam logic [W-1:0] S_END   = W'(sync_end(DISPLAY, FRONT, SYNC));
    localparam logic [W-1:0] DISP    = W'(DISPLAY);
    localparam logic         ACT     = (POL != 0);

    logic [W-1:0] pos_next;

    assign wrap     = (pos == LAST);
    assign pos_next = wrap ? '0 : pos + 1'b1;

    // decode from pos_next so sync/visible land on the same edge as pos
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos     <= LAST;
            sync    <= !ACT;
            visible <= 1'b0;
        end else if (step) begin
            pos     <= pos_next;
            sync    <= (pos_next >= S_START && pos_next <= S_END) ? ACT : !ACT;
            visible <= (pos_next < DISP);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with prescaler, run enable, strobes and frame counter
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int HSYNC_POL = VGA_POL,
    parameter int VSYNC_POL = VGA_POL,
    parameter int POS_W     = 10,
    parameter int FRAME_W   = 8,
    parameter int PIX_DIV   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam logic [POS_W-1:0] VS_PRE = POS_W'(sync_start(V_DISPLAY, V_FRONT) - 1);
    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: PIX_DIV must be within 1..16");
    end
    if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_pos
        $error("vga_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [3:0] div;
    logic       tick;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_vis;
    logic       v_vis;

    assign tick = en && (div == DIV_LAST);

    // pixel prescaler; frozen while en is low
    always_ff @(posedge clk) begin
        if (!rst_n) div <= '0;
        else if (en) div <= tick ? 4'd0 : div + 4'd1;
    end

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HSYNC_POL), .W(POS_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(tick),
        .pos(vga.hpos), .sync(vga.hsync), .visible(h_vis), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VSYNC_POL), .W(POS_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(tick && h_wrap),
        .pos(vga.vpos), .sync(vga.vsync), .visible(v_vis), .wrap(v_wrap)
    );

    assign vga.display_on = h_vis && v_vis;

    // strobes flag the tick entering a new line/frame; frame_cnt counts vsync assertions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.frame_cnt   <= '0;
        end else begin
            vga.line_start  <= tick && h_wrap;
            vga.frame_start <= tick && h_wrap && v_wrap;
            if (tick && h_wrap && vga.vpos == VS_PRE) vga.frame_cnt <= vga.frame_cnt + FRAME_W'(1);
        end
    end
endmodule
